// File: rtl/tipi_nib_if.sv
// RPi-facing nibble bus of the TIPI transfer engine.
// The RPi drives strobe/direction/select/write nibble; the FPGA returns read nibble, enable and ack.
interface tipi_nib_if;
  logic       r_strb;
  logic       r_dir;
  logic [1:0] r_sel;
  logic [3:0] r_nib_in;
  logic [3:0] r_nib_out;
  logic       r_nib_oe;
  logic       r_ack;

  modport master (
    output r_strb, r_dir, r_sel, r_nib_in,
    input  r_nib_out, r_nib_oe, r_ack
  );

  modport slave (
    input  r_strb, r_dir, r_sel, r_nib_in,
    output r_nib_out, r_nib_oe, r_ack
  );
endinterface

// File: rtl/tipi_nib_link.sv
// RPi-side TIPI transfer engine: assembles toggle-strobed nibble pairs into RC/RD byte
// writes and serves coherent TC/TD byte reads, high nibble first.
module tipi_nib_link #(
  parameter int SYNC_STAGES = 2,
  parameter int TO_W        = 10,
  parameter int TIMEOUT     = 1000
) (
  input  logic       clk,
  input  logic       r_nibrst,
  tipi_nib_if.slave  rpi,
  input  logic [7:0] tc_byte,
  input  logic [7:0] td_byte,
  output logic [7:0] rc_byte,
  output logic [7:0] rd_byte,
  output logic       rc_wr,
  output logic       rd_wr,
  output logic       link_err
);

  typedef enum logic {IDLE, HI} state_t;

  // {strb, dir, sel[1:0], nib[3:0]} all ride the same synchroniser so they stay aligned
  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic                        strb_prev_q;
  logic                        ev_q;
  logic [6:0]                  ev_data_q;

  always_ff @(posedge clk) begin
    if (!r_nibrst) begin
      sync_q      <= '0;
      strb_prev_q <= 1'b0;
      ev_q        <= 1'b0;
      ev_data_q   <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0],
                      {rpi.r_strb, rpi.r_dir, rpi.r_sel, rpi.r_nib_in}};
      strb_prev_q <= sync_q[SYNC_STAGES-1][7];
      ev_q        <= sync_q[SYNC_STAGES-1][7] ^ strb_prev_q;
      ev_data_q   <= sync_q[SYNC_STAGES-1][6:0];
    end
  end

  logic       ev_dir;
  logic [1:0] ev_sel;
  logic [3:0] ev_nib;
  logic       ev_legal;
  logic [7:0] rd_src;

  assign ev_dir   = ev_data_q[6];
  assign ev_sel   = ev_data_q[5:4];
  assign ev_nib   = ev_data_q[3:0];
  // writes may only target RC/RD (sel 0/1), reads only TC/TD (sel 2/3)
  assign ev_legal = ev_dir ^ ev_sel[1];
  assign rd_src   = ev_sel[0] ? td_byte : tc_byte;

  state_t     state_q;
  logic [3:0] hi_q;
  logic [2:0] ses_q;
  logic [7:0] rbuf_q;
  logic [3:0] nib_out_q;
  logic       oe_q;
  logic       ack_q;
  logic [7:0] rc_q;
  logic [7:0] rd_q;
  logic       rc_wr_q;
  logic       rd_wr_q;
  logic       err_q;
  logic [TO_W-1:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (!r_nibrst) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      ses_q     <= '0;
      rbuf_q    <= '0;
      nib_out_q <= '0;
      oe_q      <= 1'b0;
      ack_q     <= 1'b0;
      rc_q      <= '0;
      rd_q      <= '0;
      rc_wr_q   <= 1'b0;
      rd_wr_q   <= 1'b0;
      err_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      rc_wr_q <= 1'b0;
      rd_wr_q <= 1'b0;
      if (ev_q) begin
        ack_q    <= ~ack_q;
        to_cnt_q <= '0;
        if (!ev_legal) begin
          err_q <= 1'b1;
        end else if (state_q == HI && ses_q == {ev_sel, ev_dir}) begin
          state_q <= IDLE;
          if (ev_dir) begin
            if (ev_sel[0]) begin
              rd_q    <= {hi_q, ev_nib};
              rd_wr_q <= 1'b1;
            end else begin
              rc_q    <= {hi_q, ev_nib};
              rc_wr_q <= 1'b1;
            end
          end else begin
            nib_out_q <= rbuf_q[3:0];
          end
        end else begin
          // first nibble, or a change of sel/dir that abandons the partial byte
          state_q <= HI;
          ses_q   <= {ev_sel, ev_dir};
          if (ev_dir) begin
            hi_q <= ev_nib;
            oe_q <= 1'b0;
          end else begin
            rbuf_q    <= rd_src;
            nib_out_q <= rd_src[7:4];
            oe_q      <= 1'b1;
          end
        end
      end else if (state_q == HI) begin
        if (to_cnt_q == TO_W'(TIMEOUT)) begin
          state_q <= IDLE;
          oe_q    <= 1'b0;
          err_q   <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end
    end
  end

  assign rpi.r_nib_out = nib_out_q;
  assign rpi.r_nib_oe  = oe_q;
  assign rpi.r_ack     = ack_q;
  assign rc_byte       = rc_q;
  assign rd_byte       = rd_q;
  assign rc_wr         = rc_wr_q;
  assign rd_wr         = rd_wr_q;
  assign link_err      = err_q;

endmodule
